sw_debounce: RTL and testbench
==============================

SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 SHALL have parameter NBITS, default 4: number of raw switch/button inputs debounced.
REQ-002 SHALL have parameter NTAPS, default 6: width of the timebase tap bus.
REQ-003 SHALL have parameter TAP_SEL, default 0: index of the tap whose rising edge is the debounce tick.
REQ-004 SHALL have parameter STABLE_TICKS, default 4, legal range 1..255: consecutive ticks an input must stay changed before commit.
REQ-005 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-007 SHALL have port taps, input, NTAPS: coarse timebase taps, synchronous to clk.
REQ-008 SHALL have port raw, input, NBITS: asynchronous raw pin levels.
REQ-009 SHALL have port val, output, NBITS: debounced stable levels.
REQ-010 SHALL have port rise, output, NBITS: one-cycle pulse per bit on a committed 0->1.
REQ-011 SHALL have port fall, output, NBITS: one-cycle pulse per bit on a committed 1->0.
REQ-012 SHALL have port evt_valid, output, 1: change event pending.
REQ-013 SHALL have port evt_ready, input, 1: consumer accepts the event.
REQ-014 SHALL have port evt_data, output, NBITS: val snapshot at the latest commit.
REQ-015 SHALL have port evt_ovf, output, 1: at least one event was overwritten while pending.

Function
REQ-016 SHALL pass each raw bit through a 2-flop synchronizer (s = second stage); synchronizer reset value 0.
REQ-017 SHALL register taps[TAP_SEL] as tap_q (reset 0); tick = taps[TAP_SEL] & ~tap_q, so a high tap at reset release yields a tick on the first cycle.
REQ-018 SHALL run a per-bit FSM with states IDLE (s == val) and PEND (s != val), plus a counter cnt of width clog2(STABLE_TICKS+1).
REQ-019 In IDLE, when s != val, SHALL enter PEND with cnt = 0; ticks in IDLE are ignored.
REQ-020 In PEND, when s == val, SHALL return to IDLE and clear cnt without commit (glitch rejected), regardless of tick.
REQ-021 In PEND, on a tick with s != val, SHALL increment cnt; on the tick where cnt == STABLE_TICKS-1, SHALL commit: val toggles at the next edge, rise or fall pulses for exactly that one cycle, FSM returns to IDLE, and cnt clears.
REQ-022 Commit latency SHALL be exactly STABLE_TICKS ticks after s first differs from val, plus 2 synchronizer cycles from raw.
REQ-023 Multiple bits committing in the same cycle SHALL produce one combined event.
REQ-024 On any commit, SHALL load evt_data with the new val and set evt_valid = 1 at the same edge val updates.
REQ-025 evt_valid SHALL stay 1 and evt_data SHALL stay stable until evt_valid & evt_ready; evt_valid then clears at the next edge.
REQ-026 A commit while evt_valid = 1 and evt_ready = 0 SHALL overwrite evt_data and set evt_ovf (sticky).
REQ-027 A commit in the same cycle as a handshake SHALL keep evt_valid = 1 with the new data and SHALL NOT set evt_ovf.
REQ-028 evt_ovf SHALL clear on the edge following a handshake, unless REQ-026 sets it in that cycle.
REQ-029 evt_ready while evt_valid = 0 SHALL have no effect.

Reset
REQ-030 While rst_n = 0 at a clk edge, SHALL clear synchronizers, tap_q, all FSMs (IDLE), cnt, val, rise, fall, evt_valid, evt_data, and evt_ovf to 0.
REQ-031 Reset mid-PEND SHALL discard the partial count; after release, bits with raw = 1 SHALL debounce to 1 through the normal PEND path and generate an event.

Structure
REQ-032 SHALL place FSM state encodings (IDLE = 0, PEND = 1) and the cnt width function in shared package sw_debounce_pkg.
REQ-033 SHALL implement the per-bit synchronizer, FSM, and counter as sub-module debounce_bit, instantiated NBITS times; event and handshake logic stay in sw_debounce.

Verification (NBITS = 4, TAP_SEL = 0, STABLE_TICKS = 4, taps[0] toggling every 8 clk, so a tick every 16 clk)
REQ-034 SHALL test reset release with raw = 4'b1010 held: val = 0 initially, then val = 1010 on the 4th tick; rise = 1010 for 1 cycle; evt_valid = 1 with evt_data = 1010.
REQ-035 SHALL test a raw[0] high pulse of 20 clk spanning one tick: val, rise, and evt_valid stay 0.
REQ-036 SHALL test raw[1] bouncing 5 times within 40 clk and then held 1: exactly one rise[1] pulse, on the 4th tick after the last bounce.
REQ-037 SHALL test evt_ready = 0 with two commits (0001, then 0011): evt_data = 0011 and evt_ovf = 1; then evt_ready = 1 for 1 cycle, after which evt_valid = 0 and evt_ovf = 0.
REQ-038 SHALL test a commit coinciding with evt_valid & evt_ready: evt_valid stays 1, evt_data is the new value, and evt_ovf = 0.
REQ-039 SHALL test rst_n = 0 for 1 cycle after 3 ticks of PEND on raw[2]: all outputs are 0, and val[2] commits only 4 ticks after release.

Source files
------------

// File: rtl/sw_debounce_pkg.sv
// sw_debounce_pkg: shared FSM encoding and counter sizing for the switch debouncer
package sw_debounce_pkg;
   typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_e;
   function automatic int cnt_w(input int stable_ticks);
      return $clog2(stable_ticks + 1);
   endfunction
endpackage

// File: rtl/sw_debounce_if.sv
// sw_debounce_if: change-event handshake between the debouncer and its consumer
interface sw_debounce_if #(parameter int NBITS = 4);
   logic             evt_valid;
   logic             evt_ready;
   logic [NBITS-1:0] evt_data;
   logic             evt_ovf;
   modport master (output evt_valid, evt_data, evt_ovf, input evt_ready);
   modport slave  (input evt_valid, evt_data, evt_ovf, output evt_ready);
endinterface

// File: rtl/sw_debounce_bit.sv
// debounce_bit: per-input synchronizer, IDLE/PEND FSM and stable-tick counter
module debounce_bit
   import sw_debounce_pkg::*;
#(
   parameter int STABLE_TICKS = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   input  logic tick,
   output logic val,
   output logic rise,
   output logic fall,
   output logic commit
);
   localparam int CW = cnt_w(STABLE_TICKS);
   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          s1_q, s1_d, s_q, s_d, val_q, val_d, rise_q, rise_d, fall_q, fall_d;
   logic          differ, last;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         s1_q    <= 1'b0;
         s_q     <= 1'b0;
         val_q   <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         s1_q    <= s1_d;
         s_q     <= s_d;
         val_q   <= val_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end
   // ticks seen in IDLE never count; the count starts only once PEND is entered
   always_comb begin
      differ  = s_q != val_q;
      last    = cnt_q == CW'(STABLE_TICKS - 1);
      state_d = (state_q == IDLE) ? (differ ? PEND : IDLE)
              : (!differ || (tick && last)) ? IDLE : PEND;
      cnt_d   = (state_q == PEND && differ) ? (tick ? (last ? '0 : cnt_q + CW'(1)) : cnt_q) : '0;
   end
   always_comb begin
      commit = state_q == PEND && differ && tick && last;
      s1_d   = raw;
      s_d    = s1_q;
      val_d  = val_q ^ commit;
      rise_d = commit & ~val_q;
      fall_d = commit & val_q;
   end
   assign val  = val_q;
   assign rise = rise_q;
   assign fall = fall_q;
endmodule

// File: rtl/sw_debounce.sv
// sw_debounce: debounces NBITS raw inputs on a tap-derived tick and reports
// committed changes through a single-entry valid/ready event with overflow flag
module sw_debounce
   import sw_debounce_pkg::*;
#(
   parameter int NBITS        = 4,
   parameter int NTAPS        = 6,
   parameter int TAP_SEL      = 0,
   parameter int STABLE_TICKS = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NTAPS-1:0] taps,
   input  logic [NBITS-1:0] raw,
   output logic [NBITS-1:0] val,
   output logic [NBITS-1:0] rise,
   output logic [NBITS-1:0] fall,
   sw_debounce_if.master    evt
);
   logic             tap_q, tap_d, tick, unused_taps, any, hs;
   logic             evt_valid_q, evt_valid_d, evt_ovf_q, evt_ovf_d;
   logic [NBITS-1:0] evt_data_q, evt_data_d, commit;
   for (genvar i = 0; i < NBITS; i++) begin : g_bit
      debounce_bit #(.STABLE_TICKS(STABLE_TICKS)) u_bit (
         .clk    (clk),
         .rst_n  (rst_n),
         .raw    (raw[i]),
         .tick   (tick),
         .val    (val[i]),
         .rise   (rise[i]),
         .fall   (fall[i]),
         .commit (commit[i])
      );
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tap_q       <= 1'b0;
         evt_valid_q <= 1'b0;
         evt_data_q  <= '0;
         evt_ovf_q   <= 1'b0;
      end else begin
         tap_q       <= tap_d;
         evt_valid_q <= evt_valid_d;
         evt_data_q  <= evt_data_d;
         evt_ovf_q   <= evt_ovf_d;
      end
   end
   // a commit coinciding with a handshake replaces the event without overflow
   always_comb begin
      tap_d       = taps[TAP_SEL];
      tick        = taps[TAP_SEL] & ~tap_q;
      unused_taps = ^taps;
      any         = |commit;
      hs          = evt_valid_q & evt.evt_ready;
      evt_valid_d = any | (evt_valid_q & ~hs);
      evt_data_d  = any ? (val ^ commit) : evt_data_q;
      evt_ovf_d   = (any & evt_valid_q & ~evt.evt_ready) | (evt_ovf_q & ~hs);
   end
   assign evt.evt_valid = evt_valid_q;
   assign evt.evt_data  = evt_data_q;
   assign evt.evt_ovf   = evt_ovf_q;
endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: directed scenarios plus random stimulus, every cycle checked
// against a timestamp-based reference model (ticks counted since a bit began to differ)
module tb_sw_debounce;
   localparam int NB = 4, ST = 4, MAXC = 8192;
   logic          clk = 1'b0;
   logic          rst_n;
   logic [5:0]    taps;
   logic [NB-1:0] raw, val, rise, fall;
   sw_debounce_if #(.NBITS(NB)) evt_if ();
   sw_debounce #(.NBITS(NB), .NTAPS(6), .TAP_SEL(0), .STABLE_TICKS(ST)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .taps  (taps),
      .raw   (raw),
      .val   (val),
      .rise  (rise),
      .fall  (fall),
      .evt   (evt_if.master)
   );
   always #5 clk = ~clk;
   int vectors = 0, errors = 0, cyc = 0;
   int rise_cnt [NB];
   int first_diff [NB] = '{default: -1};
   int ticks_upto [MAXC];
   logic [NB-1:0] m_s1 = '0, m_s = '0, m_val = '0, m_rise = '0, m_fall = '0, m_data = '0;
   logic          m_tapq = 1'b0, m_valid = 1'b0, m_ovf = 1'b0;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask
   // a bit commits on the tick that makes ST ticks strictly after its first differing cycle
   function automatic logic [NB-1:0] m_commit();
      logic [NB-1:0] cm = '0;
      logic tk = rst_n && taps[0] && !m_tapq;
      int now = (cyc > 0 ? ticks_upto[cyc-1] : 0) + int'(tk);
      for (int b = 0; b < NB; b++)
         cm[b] = rst_n && tk && m_s[b] != m_val[b] && first_diff[b] >= 0 &&
                 (now - ticks_upto[first_diff[b]]) == ST;
      return cm;
   endfunction
   task automatic model_edge();
      logic [NB-1:0] cm = m_commit();
      logic tk = rst_n && taps[0] && !m_tapq;
      logic hs;
      ticks_upto[cyc] = (cyc > 0 ? ticks_upto[cyc-1] : 0) + int'(tk);
      if (!rst_n) begin
         {m_s1, m_s, m_val, m_rise, m_fall, m_data} = '0;
         {m_tapq, m_valid, m_ovf} = '0;
         for (int b = 0; b < NB; b++) first_diff[b] = -1;
      end else begin
         for (int b = 0; b < NB; b++)
            if (m_s[b] == m_val[b] || cm[b]) first_diff[b] = -1;
            else if (first_diff[b] < 0) first_diff[b] = cyc;
         hs      = m_valid && evt_if.evt_ready;
         m_ovf   = (|cm && m_valid && !evt_if.evt_ready) || (m_ovf && !hs);
         m_valid = |cm || (m_valid && !hs);
         if (|cm) m_data = m_val ^ cm;
         m_rise  = cm & ~m_val;
         m_fall  = cm & m_val;
         m_val   = m_val ^ cm;
         m_s     = m_s1;
         m_s1    = raw;
         m_tapq  = taps[0];
      end
   endtask
   task automatic drive_taps();
      taps = {5'($urandom), 1'((cyc >> 3) & 1)};
   endtask
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("val", 32'(val), 32'(m_val));
      check("rise", 32'(rise), 32'(m_rise));
      check("fall", 32'(fall), 32'(m_fall));
      check("evt_valid", 32'(evt_if.evt_valid), 32'(m_valid));
      check("evt_data", 32'(evt_if.evt_data), 32'(m_data));
      check("evt_ovf", 32'(evt_if.evt_ovf), 32'(m_ovf));
      for (int b = 0; b < NB; b++) if (rise[b]) rise_cnt[b]++;
      cyc++;
      if (cyc >= MAXC) begin
         $display("FAIL cycle_budget: got %0d cycles expected < %0d", cyc, MAXC);
         $fatal(1, "cycle budget exhausted");
      end
      drive_taps();
   endtask
   task automatic wait_val(input logic [NB-1:0] want, input string tag, input int budget);
      int n = 0;
      while (val !== want && n < budget) begin
         step();
         n++;
      end
      check(tag, 32'(val), 32'(want));
   endtask
   initial begin
      int n, k, r1;
      logic [NB-1:0] seen;
      rst_n = 1'b0;
      raw = 4'b1010;
      evt_if.evt_ready = 1'b0;
      drive_taps();
      repeat (3) step();
      check("rst_val", 32'(val), 0);
      check("rst_evt_valid", 32'(evt_if.evt_valid), 0);
      rst_n = 1'b1;
      n = 0;
      while (rise == '0 && n < 200) begin
         step();
         n++;
      end
      check("release_rise", 32'(rise), 32'(4'b1010));
      check("release_val", 32'(val), 32'(4'b1010));
      check("release_evt_valid", 32'(evt_if.evt_valid), 1);
      check("release_evt_data", 32'(evt_if.evt_data), 32'(4'b1010));
      step();
      check("release_rise_1cyc", 32'(rise), 0);
      evt_if.evt_ready = 1'b1;
      step();
      evt_if.evt_ready = 1'b0;
      seen = '0;
      raw[0] = 1'b1;
      repeat (20) begin step(); seen |= rise | fall | {3'b0, evt_if.evt_valid}; end
      raw[0] = 1'b0;
      repeat (80) begin step(); seen |= rise | fall | {3'b0, evt_if.evt_valid}; end
      check("glitch_no_activity", 32'(seen), 0);
      check("glitch_val", 32'(val), 32'(4'b1010));
      raw = '0;
      evt_if.evt_ready = 1'b1;
      wait_val(4'b0000, "settle_a", 200);
      r1 = rise_cnt[1];
      for (int b = 0; b < 5; b++) begin
         raw[1] = 1'b1;
         repeat ($urandom_range(2, 4)) step();
         raw[1] = 1'b0;
         repeat ($urandom_range(2, 4)) step();
      end
      raw[1] = 1'b1;
      repeat (120) step();
      check("bounce_one_rise", 32'(rise_cnt[1] - r1), 1);
      check("bounce_val", 32'(val), 32'(4'b0010));
      raw = '0;
      wait_val(4'b0000, "settle_b", 200);
      step();
      evt_if.evt_ready = 1'b0;
      raw = 4'b0001;
      wait_val(4'b0001, "ovf_first", 200);
      raw = 4'b0011;
      wait_val(4'b0011, "ovf_second", 200);
      check("ovf_data", 32'(evt_if.evt_data), 32'(4'b0011));
      check("ovf_flag", 32'(evt_if.evt_ovf), 1);
      evt_if.evt_ready = 1'b1;
      step();
      evt_if.evt_ready = 1'b0;
      check("ovf_hs_valid", 32'(evt_if.evt_valid), 0);
      check("ovf_hs_clear", 32'(evt_if.evt_ovf), 0);
      raw = 4'b0111;
      wait_val(4'b0111, "coinc_first", 200);
      raw = 4'b1111;
      n = 0;
      do begin
         evt_if.evt_ready = |m_commit();
         step();
         n++;
      end while (!evt_if.evt_ready && n < 200);
      evt_if.evt_ready = 1'b0;
      check("coinc_valid", 32'(evt_if.evt_valid), 1);
      check("coinc_data", 32'(evt_if.evt_data), 32'(4'b1111));
      check("coinc_ovf", 32'(evt_if.evt_ovf), 0);
      evt_if.evt_ready = 1'b1;
      raw = 4'b1011;
      wait_val(4'b1011, "rstpend_setup", 200);
      raw = 4'b1111;
      repeat (3) step();
      k = 0;
      n = 0;
      while (k < 3 && n < 100) begin
         if (taps[0] && !m_tapq) k++;
         step();
         n++;
      end
      check("rstpend_pending", 32'(val[2]), 0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("rstpend_val", 32'(val), 0);
      check("rstpend_rise", 32'(rise), 0);
      check("rstpend_fall", 32'(fall), 0);
      check("rstpend_evt_valid", 32'(evt_if.evt_valid), 0);
      check("rstpend_evt_data", 32'(evt_if.evt_data), 0);
      check("rstpend_evt_ovf", 32'(evt_if.evt_ovf), 0);
      repeat (48) step();
      check("rstpend_discarded", 32'(val[2]), 0);
      wait_val(4'b1111, "rstpend_commit", 200);
      repeat (40) begin
         raw = 4'($urandom);
         if ($urandom_range(0, 15) == 0) begin
            rst_n = 1'b0;
            step();
            rst_n = 1'b1;
         end
         repeat ($urandom_range(1, 40)) begin
            evt_if.evt_ready = $urandom_range(0, 3) == 0;
            step();
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
